// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame sequencer: controller states,
// weight-count derivation and the valid/busy transfer rule.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Radix-2 FFT of 2**npoint points: npoint stages of 2**(npoint-1) butterflies.
  function automatic int calc_wcount(input int npoint);
    return npoint * (1 << (npoint - 1));
  endfunction

  function automatic logic hs_fire(input logic valid, input logic busy);
    return valid & ~busy;
  endfunction

endpackage

// File: rtl/fft_inflight_counter.sv
// Up/down occupancy counter for frames inside the FFT pipeline, with a
// saturating full flag and a sticky underflow flag.
module fft_inflight_counter #(
  parameter int MAX_COUNT = 8,
  parameter int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_underflow
);

  logic [CW-1:0] r_count;
  logic          r_underflow;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (r_count == CW'(MAX_COUNT));
  assign w_empty = (r_count == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (!w_full)  r_count <= r_count + CW'(1);
        2'b01:   if (!w_empty) r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // An emitted frame with nothing recorded in flight means the FFT and
      // this controller have lost track of each other; keep the evidence.
      if (i_dec && w_empty) r_underflow <= 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Controller in front of full_parallel_fft: streams twiddle weights from an
// external memory into the FFT, then gates frame traffic while tracking occupancy.
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter  int NPOINT       = 3,
  parameter  int WIDTH        = 16,
  parameter  int WCOUNT       = calc_wcount(NPOINT),
  parameter  int MAX_INFLIGHT = 8,
  localparam int N            = 2 ** NPOINT,
  localparam int AW           = $clog2(WCOUNT),
  localparam int IW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  output logic                 cfg_done,
  output logic                 wt_rd_en,
  output logic [AW-1:0]        wt_rd_addr,
  input  logic [WIDTH-1:0]     wt_rd_real,
  input  logic [WIDTH-1:0]     wt_rd_imag,
  output logic                 fft_weight_valid,
  output logic [WIDTH-1:0]     fft_weight_real,
  output logic [WIDTH-1:0]     fft_weight_imag,
  input  logic                 up_valid,
  output logic                 up_busy,
  input  logic [WIDTH*N-1:0]   up_real,
  input  logic [WIDTH*N-1:0]   up_imag,
  output logic                 fft_din_valid,
  input  logic                 fft_din_busy,
  output logic [WIDTH*N-1:0]   fft_din_real,
  output logic [WIDTH*N-1:0]   fft_din_imag,
  input  logic                 fft_dout_valid,
  input  logic                 dn_busy,
  output logic [IW-1:0]        inflight,
  output logic                 err_underflow
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WCOUNT - 1);

  state_e        r_state;
  logic          r_cfg_done;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_wt_valid;

  logic          w_run;
  logic          w_full;
  logic          w_in_fire;
  logic          w_out_fire;
  logic [IW-1:0] w_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cfg_done <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wt_valid <= 1'b0;
    end else begin
      // Memory data lags the read enable by one cycle, so valid does too.
      r_wt_valid <= r_rd_en;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_state   <= ST_LOAD;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        ST_LOAD: begin
          if (r_rd_en) begin
            if (r_rd_addr == LAST_ADDR) begin
              r_rd_en   <= 1'b0;
              r_rd_addr <= '0;
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end else begin
            // Last weight is on the FFT port this cycle; open the gate next.
            r_state    <= ST_RUN;
            r_cfg_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cfg_start) begin
            r_state    <= ST_DRAIN;
            r_cfg_done <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_inflight == '0) begin
            r_state   <= ST_LOAD;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_run      = (r_state == ST_RUN);
  assign w_in_fire  = hs_fire(fft_din_valid, fft_din_busy);
  assign w_out_fire = hs_fire(fft_dout_valid, dn_busy);

  fft_inflight_counter #(
    .MAX_COUNT (MAX_INFLIGHT),
    .CW        (IW)
  ) u_inflight (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inc       (w_in_fire),
    .i_dec       (w_out_fire),
    .o_count     (w_inflight),
    .o_full      (w_full),
    .o_underflow (err_underflow)
  );

  assign cfg_done         = r_cfg_done;
  assign wt_rd_en         = r_rd_en;
  assign wt_rd_addr       = r_rd_addr;
  assign fft_weight_valid = r_wt_valid;
  // Weight data is zeroed outside its valid window so the FFT port is quiet.
  assign fft_weight_real  = r_wt_valid ? wt_rd_real : '0;
  assign fft_weight_imag  = r_wt_valid ? wt_rd_imag : '0;

  assign fft_din_valid    = w_run && up_valid && !w_full;
  assign up_busy          = !w_run || fft_din_busy || w_full;
  assign fft_din_real     = up_real;
  assign fft_din_imag     = up_imag;
  assign inflight         = w_inflight;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed self-checking bench for fft_frame_sequencer with a 1-cycle-latency
// twiddle memory model (real = addr*1024, imag = -addr).
module tb_fft_frame_sequencer;

  localparam int NPOINT = 3;
  localparam int WIDTH  = 16;
  localparam int N      = 8;
  localparam int WCOUNT = 12;
  localparam int MAXF   = 8;
  localparam int AW     = 4;
  localparam int IW     = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_start;
  logic               cfg_done;
  logic               wt_rd_en;
  logic [AW-1:0]      wt_rd_addr;
  logic [WIDTH-1:0]   wt_rd_real;
  logic [WIDTH-1:0]   wt_rd_imag;
  logic               fft_weight_valid;
  logic [WIDTH-1:0]   fft_weight_real;
  logic [WIDTH-1:0]   fft_weight_imag;
  logic               up_valid;
  logic               up_busy;
  logic [WIDTH*N-1:0] up_real;
  logic [WIDTH*N-1:0] up_imag;
  logic               fft_din_valid;
  logic               fft_din_busy;
  logic [WIDTH*N-1:0] fft_din_real;
  logic [WIDTH*N-1:0] fft_din_imag;
  logic               fft_dout_valid;
  logic               dn_busy;
  logic [IW-1:0]      inflight;
  logic               err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .NPOINT       (NPOINT),
    .WIDTH        (WIDTH),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_done         (cfg_done),
    .wt_rd_en         (wt_rd_en),
    .wt_rd_addr       (wt_rd_addr),
    .wt_rd_real       (wt_rd_real),
    .wt_rd_imag       (wt_rd_imag),
    .fft_weight_valid (fft_weight_valid),
    .fft_weight_real  (fft_weight_real),
    .fft_weight_imag  (fft_weight_imag),
    .up_valid         (up_valid),
    .up_busy          (up_busy),
    .up_real          (up_real),
    .up_imag          (up_imag),
    .fft_din_valid    (fft_din_valid),
    .fft_din_busy     (fft_din_busy),
    .fft_din_real     (fft_din_real),
    .fft_din_imag     (fft_din_imag),
    .fft_dout_valid   (fft_dout_valid),
    .dn_busy          (dn_busy),
    .inflight         (inflight),
    .err_underflow    (err_underflow)
  );

  // Twiddle memory: registered read, contents derived from the address.
  always @(posedge clk) begin
    if (wt_rd_en) begin
      wt_rd_real <= {12'd0, wt_rd_addr} * 16'd1024;
      wt_rd_imag <= 16'd0 - {12'd0, wt_rd_addr};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    cfg_start      = 1'b0;
    up_valid       = 1'b0;
    up_real        = '0;
    up_imag        = '0;
    fft_din_busy   = 1'b0;
    fft_dout_valid = 1'b0;
    dn_busy        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_load();
    step();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int k = 0; k < 40 && !cfg_done; k++) step();
    n_tests++;
    if (cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL load_timeout: cfg_done=%b required 1", cfg_done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++;
    if ({cfg_done, wt_rd_en, wt_rd_addr, fft_weight_valid, inflight, err_underflow,
         up_busy, fft_din_valid} !== {1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: done=%b rd_en=%b addr=%0d wv=%b infl=%0d err=%b busy=%b dv=%b",
               cfg_done, wt_rd_en, wt_rd_addr, fft_weight_valid, inflight, err_underflow,
               up_busy, fft_din_valid);
    end
    n_tests++;
    if ({fft_weight_real, fft_weight_imag} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h/%h required 0/0", fft_weight_real, fft_weight_imag);
    end
  endtask

  // cfg_start at relative cycle 0; LOAD occupies cycles 1..13, RUN from 14.
  task automatic test_load_and_gating();
    logic [WIDTH*N-1:0] pat_r, pat_i;
    pat_r = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    pat_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    apply_reset();
    step();
    up_valid = 1'b1;
    up_real  = pat_r;
    up_imag  = pat_i;
    #1;
    n_tests++;
    if (up_busy !== 1'b1 || fft_din_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_idle: busy=%b dv=%b required 1/0", up_busy, fft_din_valid);
    end
    cfg_start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      logic         e_rd;
      logic         e_wv;
      logic [AW-1:0] e_addr;
      step();
      // A second request mid-load must be ignored.
      cfg_start = (k == 5);
      #1;
      e_rd   = (k >= 1 && k <= WCOUNT);
      e_addr = e_rd ? AW'(k - 1) : '0;
      e_wv   = (k >= 2 && k <= WCOUNT + 1);
      n_tests++;
      if (wt_rd_en !== e_rd || wt_rd_addr !== e_addr) begin
        n_fail++;
        $display("FAIL load_rd[%0d]: en=%b addr=%0d required %b/%0d", k, wt_rd_en, wt_rd_addr, e_rd, e_addr);
      end
      n_tests++;
      if (fft_weight_valid !== e_wv) begin
        n_fail++;
        $display("FAIL load_wv[%0d]: got %b required %b", k, fft_weight_valid, e_wv);
      end
      if (e_wv) begin
        n_tests++;
        if (fft_weight_real !== 16'((k - 2) * 1024) || fft_weight_imag !== 16'(-(k - 2))) begin
          n_fail++;
          $display("FAIL load_wdata[%0d]: got %h/%h required %h/%h", k, fft_weight_real,
                   fft_weight_imag, 16'((k - 2) * 1024), 16'(-(k - 2)));
        end
      end
      n_tests++;
      if (cfg_done !== (k == 14)) begin
        n_fail++;
        $display("FAIL load_done[%0d]: got %b required %b", k, cfg_done, (k == 14));
      end
      n_tests++;
      if (k < 14 && (up_busy !== 1'b1 || fft_din_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL gate_load[%0d]: busy=%b dv=%b required 1/0", k, up_busy, fft_din_valid);
      end else if (k == 14 && (up_busy !== 1'b0 || fft_din_valid !== 1'b1 ||
                               fft_din_real !== pat_r || fft_din_imag !== pat_i)) begin
        n_fail++;
        $display("FAIL gate_first: busy=%b dv=%b data_ok=%b required 0/1/1", up_busy, fft_din_valid,
                 (fft_din_real === pat_r && fft_din_imag === pat_i));
      end
    end
    step();
    up_valid = 1'b0;
    n_tests++;
    if (inflight !== 4'd1) begin
      n_fail++;
      $display("FAIL gate_count: inflight=%0d required 1", inflight);
    end
  endtask

  task automatic test_limit();
    apply_reset();
    run_load();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      up_valid = 1'b1;
      #1;
      n_tests++;
      if (fft_din_valid !== (i < MAXF) || up_busy !== (i >= MAXF) ||
          inflight !== IW'((i < MAXF) ? i : MAXF)) begin
        n_fail++;
        $display("FAIL limit[%0d]: dv=%b busy=%b infl=%0d", i, fft_din_valid, up_busy, inflight);
      end
    end
    step();
    fft_dout_valid = 1'b1;
    #1;
    n_tests++;
    if (inflight !== 4'd8 || fft_din_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_full: infl=%0d dv=%b required 8/0", inflight, fft_din_valid);
    end
    step();
    fft_dout_valid = 1'b0;
    #1;
    n_tests++;
    if (inflight !== 4'd7 || fft_din_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_release: infl=%0d dv=%b required 7/1", inflight, fft_din_valid);
    end
    step();
    up_valid       = 1'b0;
    fft_dout_valid = 1'b1;
    n_tests++;
    if (inflight !== 4'd8) begin
      n_fail++;
      $display("FAIL limit_ninth: infl=%0d required 8", inflight);
    end
    step();
    up_valid = 1'b1;
    #1;
    n_tests++;
    if (inflight !== 4'd7 || fft_din_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_both_pre: infl=%0d dv=%b required 7/1", inflight, fft_din_valid);
    end
    step();
    up_valid       = 1'b0;
    fft_dout_valid = 1'b0;
    n_tests++;
    if (inflight !== 4'd7) begin
      n_fail++;
      $display("FAIL limit_both: infl=%0d required 7", inflight);
    end
  endtask

  task automatic test_reconfigure();
    logic dout_pat [1:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int   exp_inf  [1:6] = '{3, 2, 1, 1, 0, 0};
    int   wv_count = 0;
    apply_reset();
    run_load();
    up_valid = 1'b1;
    repeat (3) step();
    up_valid = 1'b0;
    #1;
    n_tests++;
    if (inflight !== 4'd3) begin
      n_fail++;
      $display("FAIL reconf_setup: infl=%0d required 3", inflight);
    end
    cfg_start = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      cfg_start      = 1'b0;
      up_valid       = (k <= 6);
      fft_dout_valid = (k <= 6) ? dout_pat[k] : 1'b0;
      #1;
      if (k <= 6) begin
        n_tests++;
        if (inflight !== IW'(exp_inf[k]) || wt_rd_en !== (k == 6) || up_busy !== 1'b1 ||
            fft_din_valid !== 1'b0 || cfg_done !== 1'b0) begin
          n_fail++;
          $display("FAIL reconf_drain[%0d]: infl=%0d rd_en=%b busy=%b dv=%b done=%b",
                   k, inflight, wt_rd_en, up_busy, fft_din_valid, cfg_done);
        end
      end else begin
        n_tests++;
        if (wt_rd_en !== (k <= 17) || cfg_done !== (k == 19)) begin
          n_fail++;
          $display("FAIL reconf_load[%0d]: rd_en=%b done=%b required %b/%b",
                   k, wt_rd_en, cfg_done, (k <= 17), (k == 19));
        end
        if (fft_weight_valid) wv_count++;
        if (k == 18) begin
          n_tests++;
          if (fft_weight_real !== 16'd11264) begin
            n_fail++;
            $display("FAIL reconf_last_w: got %0d required 11264", fft_weight_real);
          end
        end
      end
    end
    n_tests++;
    if (wv_count != WCOUNT) begin
      n_fail++;
      $display("FAIL reconf_wcount: got %0d required %0d", wv_count, WCOUNT);
    end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    step();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (5) step();
    n_tests++;
    if (fft_weight_valid !== 1'b1 || fft_weight_real !== 16'd4096) begin
      n_fail++;
      $display("FAIL midrst_pre: wv=%b real=%0d required 1/4096", fft_weight_valid, fft_weight_real);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cfg_done, wt_rd_en, wt_rd_addr, fft_weight_valid, fft_weight_real, up_busy,
         fft_din_valid, inflight} !== {1'b0, 1'b0, 4'd0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL midrst_now: done=%b rd_en=%b addr=%0d wv=%b real=%0d busy=%b dv=%b infl=%0d",
               cfg_done, wt_rd_en, wt_rd_addr, fft_weight_valid, fft_weight_real, up_busy,
               fft_din_valid, inflight);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_tests++;
      if (fft_weight_valid !== 1'b0 || wt_rd_en !== 1'b0 || cfg_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_after[%0d]: wv=%b rd_en=%b done=%b required 0/0/0",
                 k, fft_weight_valid, wt_rd_en, cfg_done);
      end
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    step();
    fft_dout_valid = 1'b1;
    dn_busy        = 1'b1;
    step();
    dn_busy = 1'b0;
    n_tests++;
    if (err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_busy: err=%b required 0", err_underflow);
    end
    step();
    fft_dout_valid = 1'b0;
    n_tests++;
    if (err_underflow !== 1'b1 || inflight !== 4'd0) begin
      n_fail++;
      $display("FAIL uflow_set: err=%b infl=%0d required 1/0", err_underflow, inflight);
    end
    repeat (5) step();
    n_tests++;
    if (err_underflow !== 1'b1 || inflight !== 4'd0) begin
      n_fail++;
      $display("FAIL uflow_hold: err=%b infl=%0d required 1/0", err_underflow, inflight);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_gating();
    test_limit();
    test_reconfigure();
    test_reset_mid_load();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Controller in front of full_parallel_fft; sequences the twiddle-weight load, then gates frame traffic into the FFT.
- Weight load: reads twiddles from an external 1-cycle-latency twiddle memory and streams them serially onto the FFT weight port.
- Frame gating: input frames are blocked until configuration is complete; in-flight frames are counted so a reconfiguration never corrupts a frame inside the pipeline.

Parameters:
- NPOINT, 3, log2 of FFT points; N = 2**NPOINT.
- WIDTH, 16, bits per real/imag sample and per weight component.
- WCOUNT, NPOINT*2**(NPOINT-1), number of weights per configuration (12 at default).
- MAX_INFLIGHT, 8, maximum frames accepted but not yet emitted by the FFT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cfg_start  in  1  single-cycle pulse requesting a (re)load of weights
- cfg_done  out  1  high while weights are valid and frames may flow
- wt_rd_en  out  1  twiddle memory read enable
- wt_rd_addr  out  $clog2(WCOUNT)  twiddle memory address
- wt_rd_real / wt_rd_imag  in  WIDTH each  read data, valid the cycle after wt_rd_en
- fft_weight_valid  out  1  to FFT din_weight_valid
- fft_weight_real / fft_weight_imag  out  WIDTH each  to FFT din_weight_real/imag
- up_valid  in  1  upstream frame valid
- up_busy  out  1  upstream backpressure
- up_real / up_imag  in  WIDTH*N each  upstream frame
- fft_din_valid  out  1  to FFT din_valid
- fft_din_busy  in  1  from FFT din_busy
- fft_din_real / fft_din_imag  out  WIDTH*N each  to FFT din_real/imag
- fft_dout_valid  in  1  FFT output valid (observed only)
- dn_busy  in  1  downstream busy on the FFT output (observed only)
- inflight  out  $clog2(MAX_INFLIGHT+1)  frames currently in the FFT
- err_underflow  out  1  sticky; FFT emitted a frame while inflight==0

Behaviour:
- Transfer rule (all interfaces): a transfer occurs when valid && !busy in the same cycle.
- Reset values: state=IDLE, cfg_done=0, wt_rd_en=0, wt_rd_addr=0, fft_weight_valid=0, weight data=0, inflight=0, err_underflow=0, up_busy=1, fft_din_valid=0.
- Reset asserted mid-operation aborts everything to reset values immediately. A partial weight load is discarded and a new cfg_start is required.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE: on cfg_start go to LOAD.
- LOAD (entered at cycle T0):
  - wt_rd_en=1 for T0..T0+WCOUNT-1, with wt_rd_addr = cycle offset 0..WCOUNT-1.
  - fft_weight_valid is a 1-cycle registered copy of wt_rd_en: high T0+1..T0+WCOUNT.
  - fft_weight_real/imag = wt_rd_real/imag, combinational pass-through of memory output.
  - At T0+WCOUNT+1: state=RUN and cfg_done=1.
  - cfg_start during LOAD is ignored.
- RUN:
  - fft_din_valid = up_valid && inflight<MAX_INFLIGHT.
  - up_busy = fft_din_busy || inflight==MAX_INFLIGHT.
  - fft_din_real/imag = up_real/imag, combinational pass-through.
  - cfg_start: next cycle state=DRAIN and cfg_done=0.
- DRAIN: up_busy=1 and fft_din_valid=0. Go to LOAD in the cycle after inflight==0 is observed; if inflight is already 0, DRAIN lasts exactly 1 cycle.
- Outside RUN: up_busy=1 and fft_din_valid=0.
- inflight counter:
  - +1 on input transfer (fft_din_valid && !fft_din_busy).
  - -1 on output transfer (fft_dout_valid && !dn_busy).
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_INFLIGHT; input is gated at the limit.
  - Output transfer at inflight==0: counter stays 0, err_underflow sets and holds until reset.
- Output transfers are counted in every state, including LOAD. This is legal only with inflight==0, which then flags the error.

Decomposition:
- Package fft_ctrl_pkg: state enum (IDLE/LOAD/RUN/DRAIN), function computing WCOUNT from NPOINT, handshake-fire helper function.
- Sub-module fft_inflight_counter: up/down counter with limit, full flag and underflow flag.
- FSM, load address counter and gating stay in the top module.

Test Plan:
- Basic load (NPOINT=3, WIDTH=16): cfg_start at cycle 5; memory holds real=addr*1024, imag=-addr -> rd_en cycles 6..17, weight_valid cycles 7..18 with real 0,1024,..,11264 in order, cfg_done=1 at cycle 19.
- Gating: up_valid=1 before and during LOAD -> up_busy=1 and fft_din_valid=0 throughout; first input transfer occurs at cycle 19 with data passed unchanged.
- Backpressure and limit (MAX_INFLIGHT=8): hold FFT output silent and push 10 frames -> 8 accepted, inflight=8, up_busy=1. Release one output -> inflight=7 and the 9th frame is accepted; an input transfer and an output transfer in the same cycle leave inflight unchanged.
- Reconfigure: cfg_start in RUN with inflight=3 -> cfg_done=0 next cycle, DRAIN holds until 3 outputs complete, LOAD starts the cycle after inflight==0, 12 new weights follow.
- Reset mid-load: rst_n low at the 5th weight -> all outputs at reset values at once; after release weight_valid stays 0 until a new cfg_start.
- Underflow: fft_dout_valid=1, dn_busy=0 with inflight=0 -> err_underflow=1 and held, inflight remains 0.
